// File: rtl/logic_gate_pkg.sv
// logic_gate_pkg: shared definitions for the logic_gate_pipe unit.
//   OP_W           width of the operation code
//   OP_AND..OP_ILLEGAL  operation codes
//   MAX_LANES      largest supported number of operand lanes
//   lane_gate()    computes one result bit from one column of lane bits
package logic_gate_pkg;

  localparam int OP_W      = 3;
  localparam int MAX_LANES = 8;

  localparam logic [OP_W-1:0] OP_AND     = 3'd0;
  localparam logic [OP_W-1:0] OP_OR      = 3'd1;
  localparam logic [OP_W-1:0] OP_NAND    = 3'd2;
  localparam logic [OP_W-1:0] OP_NOR     = 3'd3;
  localparam logic [OP_W-1:0] OP_XOR     = 3'd4;
  localparam logic [OP_W-1:0] OP_XNOR    = 3'd5;
  localparam logic [OP_W-1:0] OP_NOT     = 3'd6;
  localparam logic [OP_W-1:0] OP_ILLEGAL = 3'd7;

  // Works on a single bit position: bits[i] is that bit of lane i. Lanes at
  // or above nIn are ignored, so the same function serves every N_IN.
  function automatic logic lane_gate(input logic [OP_W-1:0] op,
                                     input logic [MAX_LANES-1:0] bits,
                                     input int nIn);
    logic andR;
    logic orR;
    logic xorR;
    logic res;
    andR = 1'b1;
    orR  = 1'b0;
    xorR = 1'b0;
    for (int i = 0; i < MAX_LANES; i++) begin
      if (i < nIn) begin
        andR = andR & bits[i];
        orR  = orR  | bits[i];
        xorR = xorR ^ bits[i];
      end
    end
    case (op)
      OP_AND:  res = andR;
      OP_OR:   res = orR;
      OP_NAND: res = ~andR;
      OP_NOR:  res = ~orR;
      OP_XOR:  res = xorR;
      OP_XNOR: res = ~xorR;
      OP_NOT:  res = ~bits[0];
      default: res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/lgp_fifo.sv
// lgp_fifo: synchronous FIFO with occupancy output.
//   clk, rst_n   clock and asynchronous active-low reset (clears contents)
//   push_i       write wdata_i at the tail (ignored when full)
//   wdata_i      entry to write
//   pop_i        advance the head (ignored when empty)
//   rdata_o      current head entry
//   level_o      number of stored entries, 0..DEPTH
//   full_o       level_o == DEPTH
//   empty_o      level_o == 0
module lgp_fifo #(
  parameter int DW    = 11,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic [DW-1:0]              wdata_i,
  input  logic                       pop_i,
  output logic [DW-1:0]              rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int LW = $clog2(DEPTH+1);

  logic [DW-1:0] mem_q [DEPTH];
  logic [PW-1:0] wrPtr_q;
  logic [PW-1:0] rdPtr_q;
  logic [LW-1:0] level_q;
  logic [LW-1:0] level_d;
  logic          doPush;
  logic          doPop;

  assign full_o  = (level_q == LW'(DEPTH));
  assign empty_o = (level_q == '0);
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;
  assign rdata_o = mem_q[rdPtr_q];
  assign level_o = level_q;

  // Push and pop together leave the level unchanged.
  always_comb begin
    level_d = level_q;
    if (doPush && !doPop) begin
      level_d = level_q + LW'(1);
    end else if (doPop && !doPush) begin
      level_d = level_q - LW'(1);
    end
  end

  // Storage is cleared on reset so no stale entry can surface as the head.
  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      level_q <= '0;
    end else begin
      if (doPush) begin
        mem_q[wrPtr_q] <= wdata_i;
        wrPtr_q        <= wrPtr_q + PW'(1);
      end
      if (doPop) begin
        rdPtr_q <= rdPtr_q + PW'(1);
      end
      level_q <= level_d;
    end
  end

endmodule

// File: rtl/logic_gate_pipe.sv
// logic_gate_pipe: N_IN-lane, WIDTH-bit bitwise logic unit with a queued output.
//   clk, rst_n              clock, asynchronous active-low reset
//   in_valid/in_ready       operand handshake; in_op selects the operation,
//                           in_data carries lane i at [i*WIDTH +: WIDTH]
//   out_valid/out_ready     result handshake; out_data/out_op/out_zero show
//                           the FIFO head
//   err_illegal, clr_err    sticky illegal-op flag and its synchronous clear
//   level                   FIFO occupancy
module logic_gate_pipe
  import logic_gate_pkg::*;
#(
  parameter int WIDTH     = 8,
  parameter int N_IN      = 2,
  parameter int OUT_DEPTH = 2
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [OP_W-1:0]                in_op,
  input  logic [N_IN*WIDTH-1:0]          in_data,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [WIDTH-1:0]               out_data,
  output logic [OP_W-1:0]                out_op,
  output logic                           out_zero,
  output logic                           err_illegal,
  input  logic                           clr_err,
  output logic [$clog2(OUT_DEPTH+1)-1:0] level
);

  logic [WIDTH-1:0]      result;
  logic [WIDTH+OP_W-1:0] headEntry;
  logic                  fifoFull;
  logic                  fifoEmpty;
  logic                  accept;
  logic                  errIllegal_q;
  logic                  errIllegal_d;

  // Gather each bit position across all lanes and reduce it.
  always_comb begin
    logic [MAX_LANES-1:0] column;
    result = '0;
    for (int b = 0; b < WIDTH; b++) begin
      column = '0;
      for (int l = 0; l < N_IN; l++) begin
        column[l] = in_data[l*WIDTH + b];
      end
      result[b] = lane_gate(in_op, column, N_IN);
    end
  end

  assign in_ready  = !fifoFull;
  assign out_valid = !fifoEmpty;
  assign accept    = in_valid && in_ready;

  lgp_fifo #(
    .DW    (WIDTH + OP_W),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (accept),
    .wdata_i ({in_op, result}),
    .pop_i   (out_ready),
    .rdata_o (headEntry),
    .level_o (level),
    .full_o  (fifoFull),
    .empty_o (fifoEmpty)
  );

  assign out_data = headEntry[WIDTH-1:0];
  assign out_op   = headEntry[WIDTH+OP_W-1:WIDTH];
  assign out_zero = (out_data == '0);

  // Setting takes priority so an illegal op accepted alongside a clear is
  // never lost.
  always_comb begin
    errIllegal_d = errIllegal_q;
    if (accept && (in_op == OP_ILLEGAL)) begin
      errIllegal_d = 1'b1;
    end else if (clr_err) begin
      errIllegal_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      errIllegal_q <= 1'b0;
    end else begin
      errIllegal_q <= errIllegal_d;
    end
  end

  assign err_illegal = errIllegal_q;

endmodule

// File: tb/tb_logic_gate_pipe.sv
// tb_logic_gate_pipe: directed, table-driven bench for logic_gate_pipe with
// four 8-bit lanes and a two-entry output FIFO.
module tb_logic_gate_pipe;

  localparam int WIDTH     = 8;
  localparam int N_IN      = 4;
  localparam int OUT_DEPTH = 2;

  logic                  clk;
  logic                  rst_n;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_op;
  logic [N_IN*WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [WIDTH-1:0]      out_data;
  logic [2:0]            out_op;
  logic                  out_zero;
  logic                  err_illegal;
  logic                  clr_err;
  logic [1:0]            level;

  int vectorsApplied = 0;
  int miscompares    = 0;

  typedef struct {
    string       name;
    logic [2:0]  op;
    logic [31:0] data;
    logic [7:0]  expData;
  } vec_t;

  vec_t vecs [12];

  logic_gate_pipe #(
    .WIDTH     (WIDTH),
    .N_IN      (N_IN),
    .OUT_DEPTH (OUT_DEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_op       (in_op),
    .in_data     (in_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_op      (out_op),
    .out_zero    (out_zero),
    .err_illegal (err_illegal),
    .clr_err     (clr_err),
    .level       (level)
  );

  // 100 MHz clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    vectorsApplied++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Drives the input side; called just after a falling edge.
  task automatic applyStimulus(input logic valid, input logic [2:0] op,
                               input logic [31:0] data);
    in_valid = valid;
    in_op    = op;
    in_data  = data;
  endtask

  initial begin
    vecs[0]  = '{"nor_0F_F0",   3'd3, 32'h0000F00F, 8'h00};
    vecs[1]  = '{"nor_zero",    3'd3, 32'h00000000, 8'hFF};
    vecs[2]  = '{"xor_ramp",    3'd4, 32'h0F070301, 8'h0A};
    vecs[3]  = '{"and_ramp",    3'd0, 32'h0F070301, 8'h01};
    vecs[4]  = '{"or_ramp",     3'd1, 32'h0F070301, 8'h0F};
    vecs[5]  = '{"nand_ramp",   3'd2, 32'h0F070301, 8'hFE};
    vecs[6]  = '{"xnor_ramp",   3'd5, 32'h0F070301, 8'hF5};
    vecs[7]  = '{"not_lane0",   3'd6, 32'h0F070301, 8'hFE};
    vecs[8]  = '{"nand_ones",   3'd2, 32'hFFFFFFFF, 8'h00};
    vecs[9]  = '{"or_spread",   3'd1, 32'h18244281, 8'hFF};
    vecs[10] = '{"and_spread",  3'd0, 32'h18244281, 8'h00};
    vecs[11] = '{"xor_mix",     3'd4, 32'h00F055AA, 8'h0F};

    rst_n     = 1'b0;
    out_ready = 1'b0;
    clr_err   = 1'b0;
    applyStimulus(1'b0, 3'd0, 32'h0);

    // Reset state.
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_level", level, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_err", err_illegal, 0);
    checkOutput("rst_out_zero", out_zero, 1);
    checkOutput("rst_out_data", out_data, 0);
    checkOutput("rst_out_op", out_op, 0);

    // Table: push one word, check the head, pop it on the next edge.
    out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      applyStimulus(1'b1, vecs[i].op, vecs[i].data);
      @(negedge clk);
      applyStimulus(1'b0, 3'd0, 32'h0);
      checkOutput({vecs[i].name, "_valid"}, out_valid, 1);
      checkOutput({vecs[i].name, "_data"}, out_data, vecs[i].expData);
      checkOutput({vecs[i].name, "_op"}, out_op, vecs[i].op);
      checkOutput({vecs[i].name, "_zero"}, out_zero, vecs[i].expData == 8'h00);
      checkOutput({vecs[i].name, "_level"}, level, 1);
      @(negedge clk);
      checkOutput({vecs[i].name, "_drained"}, level, 0);
    end
    checkOutput("err_after_table", err_illegal, 0);

    // Backpressure: fill, refuse a third word, then pop one.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, 32'h00000001);
    @(negedge clk);
    checkOutput("bp_level1", level, 1);
    checkOutput("bp_ready1", in_ready, 1);
    applyStimulus(1'b1, 3'd1, 32'h00000002);
    @(negedge clk);
    checkOutput("bp_level2", level, 2);
    checkOutput("bp_ready2", in_ready, 0);
    checkOutput("bp_head_a", out_data, 8'h01);
    applyStimulus(1'b1, 3'd1, 32'h00000004);
    @(negedge clk);
    checkOutput("bp_level_full", level, 2);
    checkOutput("bp_head_stable", out_data, 8'h01);
    applyStimulus(1'b0, 3'd0, 32'h0);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_pop_level", level, 1);
    checkOutput("bp_pop_ready", in_ready, 1);
    checkOutput("bp_pop_head", out_data, 8'h02);
    // Simultaneous push and pop at level 1.
    applyStimulus(1'b1, 3'd1, 32'h00000008);
    @(negedge clk);
    checkOutput("pp_level", level, 1);
    checkOutput("pp_head", out_data, 8'h08);
    applyStimulus(1'b0, 3'd0, 32'h0);
    @(negedge clk);
    checkOutput("pp_drain_level", level, 0);
    @(negedge clk);
    checkOutput("empty_pop_level", level, 0);
    checkOutput("empty_pop_valid", out_valid, 0);

    // Illegal op and the sticky error flag.
    applyStimulus(1'b1, 3'd7, 32'hFFFFFFFF);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'h0);
    checkOutput("ill_data", out_data, 0);
    checkOutput("ill_op", out_op, 7);
    checkOutput("ill_zero", out_zero, 1);
    checkOutput("ill_err_set", err_illegal, 1);
    @(negedge clk);
    checkOutput("ill_err_sticky", err_illegal, 1);
    applyStimulus(1'b1, 3'd7, 32'h0);
    clr_err = 1'b1;
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'h0);
    checkOutput("ill_set_wins", err_illegal, 1);
    @(negedge clk);
    checkOutput("ill_clr", err_illegal, 0);
    clr_err = 1'b0;
    @(negedge clk);
    checkOutput("ill_clr_hold", err_illegal, 0);

    // Reset mid-operation with a full FIFO.
    out_ready = 1'b0;
    applyStimulus(1'b1, 3'd1, 32'h00000011);
    @(negedge clk);
    applyStimulus(1'b1, 3'd1, 32'h00000022);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'h0);
    checkOutput("mid_full", level, 2);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_valid", out_valid, 0);
    checkOutput("mid_rst_level", level, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("mid_rel_level", level, 0);
    checkOutput("mid_rel_valid", out_valid, 0);
    checkOutput("mid_rel_data", out_data, 0);
    checkOutput("mid_rel_zero", out_zero, 1);
    checkOutput("mid_rel_ready", in_ready, 1);
    applyStimulus(1'b1, 3'd1, 32'h00000033);
    @(negedge clk);
    applyStimulus(1'b0, 3'd0, 32'h0);
    checkOutput("mid_new_level", level, 1);
    checkOutput("mid_new_head", out_data, 8'h33);
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("mid_final_level", level, 0);
    checkOutput("mid_final_data", out_data, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectorsApplied, miscompares);
    $finish;
  end

endmodule
